// File: rtl/zion_riscv_isa_lib_add_sub_pkg.sv
// zion_riscv_isa_lib_add_sub_pkg: shared kinds, op-bit positions and buffer entry type for the add/sub issue stage.
//   add_sub_kind_e : 4-bit decoded micro-op kind
//   OP_*_BIT       : positions in the one-hot op vector
//   entry_t        : skid-buffer entry sized for the widest build (RV64, TAG_W <= TAG_MAX_W)
package zion_riscv_isa_lib_add_sub_pkg;
   typedef enum logic [3:0] {
      ADD   = 4'd0,
      ADDI  = 4'd1,
      SUB   = 4'd2,
      ADDW  = 4'd3,
      ADDIW = 4'd4,
      SUBW  = 4'd5,
      SLT   = 4'd6,
      SLTU  = 4'd7,
      SLTI  = 4'd8,
      SLTIU = 4'd9,
      BLT   = 4'd10,
      BLTU  = 4'd11,
      BGE   = 4'd12,
      BGEU  = 4'd13,
      LDST  = 4'd14,
      AUIPC = 4'd15
   } add_sub_kind_e;
   localparam int OP_ADD_BIT = 0;
   localparam int OP_SUB_BIT = 1;
   localparam int OP_W_BIT   = 2;
   localparam int XLEN_MAX   = 64;
   localparam int OP_MAX_W   = 3;
   localparam int TAG_MAX_W  = 16;
   typedef struct packed {
      logic [OP_MAX_W-1:0]  op;
      logic [XLEN_MAX-1:0]  s1;
      logic [XLEN_MAX-1:0]  s2;
      logic                 unsignedFlg;
      logic [TAG_MAX_W-1:0] tag;
   } entry_t;
   function automatic logic isWKind(input add_sub_kind_e kind);
      return kind inside {ADDW, ADDIW, SUBW};
   endfunction
endpackage

// File: rtl/zion_riscv_isa_lib_add_sub_issue_if.sv
// zion_riscv_isa_lib_add_sub_issue_if: upstream/downstream handshake bundle for the add/sub issue stage.
//   slave  : the issue stage (accepts iVld/iKind/operands, drives oVld/oOp/oS1/oS2/oTag/oIllegal)
//   master : the environment driving it
//   ZION_ADD_SUB_ISSUE_PERF_EN adds oIssueCnt/oStallCnt.
interface zion_riscv_isa_lib_add_sub_issue_if
   import zion_riscv_isa_lib_add_sub_pkg::*;
#(
   parameter int RV64  = 0,
   parameter int TAG_W = 4
);
   localparam int CPU_WIDTH = 32 * (RV64 + 1);
   logic                 iFlush;
   logic                 iVld;
   logic                 oRdy;
   add_sub_kind_e        iKind;
   logic [CPU_WIDTH-1:0] iRs1;
   logic [CPU_WIDTH-1:0] iRs2;
   logic [CPU_WIDTH-1:0] iImm;
   logic [CPU_WIDTH-1:0] iPc;
   logic [TAG_W-1:0]     iTag;
   logic                 oVld;
   logic                 iRdy;
   logic [RV64+1:0]      oOp;
   logic [CPU_WIDTH-1:0] oS1;
   logic [CPU_WIDTH-1:0] oS2;
   logic                 oUnsignedFlg;
   logic [TAG_W-1:0]     oTag;
   logic                 oIllegal;
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
   logic [31:0]          oIssueCnt;
   logic [31:0]          oStallCnt;
`endif
   modport slave (
      input  iFlush, iVld, iKind, iRs1, iRs2, iImm, iPc, iTag, iRdy,
      output oRdy, oVld, oOp, oS1, oS2, oUnsignedFlg, oTag, oIllegal
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
      , oIssueCnt, oStallCnt
`endif
   );
   modport master (
      output iFlush, iVld, iKind, iRs1, iRs2, iImm, iPc, iTag, iRdy,
      input  oRdy, oVld, oOp, oS1, oS2, oUnsignedFlg, oTag, oIllegal
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
      , oIssueCnt, oStallCnt
`endif
   );
endinterface

// File: rtl/zion_riscv_isa_lib_add_sub_issue_dec.sv
// zion_riscv_isa_lib_add_sub_issue_dec: combinational kind decoder for the add/sub issue stage.
//   iKind        : micro-op kind
//   oOp          : one-hot add/sub plus .W bit (RV64 only)
//   oSelPc       : operand 1 is pc instead of rs1
//   oSelImm      : operand 2 is imm instead of rs2
//   oUnsignedFlg : unsigned compare consumer
//   oIllegal     : kind unsupported by this datapath width
module zion_riscv_isa_lib_add_sub_issue_dec
   import zion_riscv_isa_lib_add_sub_pkg::*;
#(
   parameter int RV64 = 0
) (
   input  add_sub_kind_e   iKind,
   output logic [RV64+1:0] oOp,
   output logic            oSelPc,
   output logic            oSelImm,
   output logic            oUnsignedFlg,
   output logic            oIllegal
);
   logic addBit, subBit, wBit;
   always_comb begin
      addBit       = 1'b0;
      subBit       = 1'b0;
      oSelPc       = 1'b0;
      oSelImm      = 1'b0;
      oUnsignedFlg = 1'b0;
      case (iKind)
         ADD, ADDW:               addBit = 1'b1;
         ADDI, ADDIW, LDST:       begin addBit = 1'b1; oSelImm = 1'b1; end
         AUIPC:                   begin addBit = 1'b1; oSelImm = 1'b1; oSelPc = 1'b1; end
         SUB, SUBW, SLT, BLT, BGE: subBit = 1'b1;
         SLTU, BLTU, BGEU:        begin subBit = 1'b1; oUnsignedFlg = 1'b1; end
         SLTI:                    begin subBit = 1'b1; oSelImm = 1'b1; end
         SLTIU:                   begin subBit = 1'b1; oSelImm = 1'b1; oUnsignedFlg = 1'b1; end
         default:                 ;
      endcase
      // *W kinds only exist on RV64; on RV32 they become an all-zero illegal op
      oIllegal = isWKind(iKind) && (RV64 == 0);
      wBit     = isWKind(iKind) && !oIllegal;
      if (oIllegal) begin
         addBit       = 1'b0;
         subBit       = 1'b0;
         oUnsignedFlg = 1'b0;
      end
      oOp = (RV64 + 2)'({wBit, subBit, addBit});
   end
endmodule

// File: rtl/zion_riscv_isa_lib_add_sub_issue.sv
// zion_riscv_isa_lib_add_sub_issue: registered add/sub issue stage with a 2-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport carrying upstream valid/ready + operands and downstream valid/ready + op
//   ZION_ADD_SUB_ISSUE_PERF_EN adds issue/stall counters on bus.oIssueCnt/bus.oStallCnt.
module zion_riscv_isa_lib_add_sub_issue
   import zion_riscv_isa_lib_add_sub_pkg::*;
#(
   parameter int RV64  = 0,
   parameter int TAG_W = 4
) (
   input logic                               clk,
   input logic                               rst_n,
   zion_riscv_isa_lib_add_sub_issue_if.slave bus
);
   localparam int CPU_WIDTH = 32 * (RV64 + 1);
   logic [RV64+1:0] decOp;
   logic            selPc, selImm, decUnsigned, decIllegal;
   entry_t          inEntry, head;
   entry_t          mem [2];
   logic            rdPtr, wrPtr, rdyQ, illegalQ, accept, issue;
   logic [1:0]      count, countNext;
   logic            unusedHead;
   zion_riscv_isa_lib_add_sub_issue_dec #(.RV64(RV64)) uDec (
      .iKind        (bus.iKind),
      .oOp          (decOp),
      .oSelPc       (selPc),
      .oSelImm      (selImm),
      .oUnsignedFlg (decUnsigned),
      .oIllegal     (decIllegal)
   );
   // rdyQ mirrors (count < 2) one register stage early, so ready never depends on iRdy
   assign accept    = bus.iVld & rdyQ & ~bus.iFlush;
   assign issue     = (count != 2'd0) & bus.iRdy;
   assign countNext = bus.iFlush ? 2'd0 : count + 2'(accept) - 2'(issue);
   always_comb begin
      inEntry             = '0;
      inEntry.op          = OP_MAX_W'(decOp);
      inEntry.s1          = decIllegal ? '0 : XLEN_MAX'(selPc ? bus.iPc : bus.iRs1);
      inEntry.s2          = decIllegal ? '0 : XLEN_MAX'(selImm ? bus.iImm : bus.iRs2);
      inEntry.unsignedFlg = decUnsigned;
      inEntry.tag         = TAG_MAX_W'(bus.iTag);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         rdPtr    <= 1'b0;
         wrPtr    <= 1'b0;
         count    <= 2'd0;
         rdyQ     <= 1'b1;
         illegalQ <= 1'b0;
      end else begin
         if (accept) mem[wrPtr] <= inEntry;
         rdPtr    <= bus.iFlush ? 1'b0 : rdPtr ^ issue;
         wrPtr    <= bus.iFlush ? 1'b0 : wrPtr ^ accept;
         count    <= countNext;
         rdyQ     <= countNext != 2'd2;
         illegalQ <= illegalQ | (accept & decIllegal);
      end
   end
   assign head             = mem[rdPtr];
   assign bus.oVld         = count != 2'd0;
   assign bus.oRdy         = rdyQ;
   assign bus.oOp          = head.op[RV64+1:0];
   assign bus.oS1          = head.s1[CPU_WIDTH-1:0];
   assign bus.oS2          = head.s2[CPU_WIDTH-1:0];
   assign bus.oUnsignedFlg = head.unsignedFlg;
   assign bus.oTag         = head.tag[TAG_W-1:0];
   assign bus.oIllegal     = illegalQ;
   // entries are sized for the widest build; narrower builds leave upper bits unread
   assign unusedHead       = ^{head.op, head.s1, head.s2, head.tag};
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
   logic [31:0] issueCnt, stallCnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issueCnt <= '0;
         stallCnt <= '0;
      end else begin
         issueCnt <= issueCnt + 32'(issue);
         stallCnt <= stallCnt + 32'(bus.oVld & ~bus.iRdy);
      end
   end
   assign bus.oIssueCnt = issueCnt;
   assign bus.oStallCnt = stallCnt;
`endif
endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_issue.sv
// tb_zion_riscv_isa_lib_add_sub_issue: scoreboard bench for RV64 and RV32 builds of the add/sub issue stage.
module tb_zion_riscv_isa_lib_add_sub_issue;
   import zion_riscv_isa_lib_add_sub_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   zion_riscv_isa_lib_add_sub_issue_if #(.RV64(1), .TAG_W(4)) b64 ();
   zion_riscv_isa_lib_add_sub_issue_if #(.RV64(0), .TAG_W(4)) b32 ();
   zion_riscv_isa_lib_add_sub_issue #(.RV64(1), .TAG_W(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
   zion_riscv_isa_lib_add_sub_issue #(.RV64(0), .TAG_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   typedef struct {
      logic [2:0]  op;
      logic [63:0] s1;
      logic [63:0] s2;
      logic        uns;
      logic [3:0]  tag;
   } exp_t;
   exp_t q64[$];
   exp_t q32[$];
   int checks = 0;
   int errors = 0;
   function automatic exp_t mk(input logic [2:0] op, input logic [63:0] s1, s2, input logic uns, input logic [3:0] tag);
      exp_t e;
      e.op = op; e.s1 = s1; e.s2 = s2; e.uns = uns; e.tag = tag;
      return e;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b64.oVld && b64.iRdy) begin
         checks++;
         if (q64.size() == 0) begin
            errors++;
            $display("FAIL mon64: unexpected issue tag %0d", b64.oTag);
         end else begin
            e = q64.pop_front();
            if ({b64.oOp, b64.oS1, b64.oS2, b64.oUnsignedFlg, b64.oTag} !== {e.op, e.s1, e.s2, e.uns, e.tag}) begin
               errors++;
               $display("FAIL mon64: got op=%b s1=%h s2=%h u=%b tag=%0d expected op=%b s1=%h s2=%h u=%b tag=%0d",
                        b64.oOp, b64.oS1, b64.oS2, b64.oUnsignedFlg, b64.oTag, e.op, e.s1, e.s2, e.uns, e.tag);
            end
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b32.oVld && b32.iRdy) begin
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL mon32: unexpected issue tag %0d", b32.oTag);
         end else begin
            e = q32.pop_front();
            if ({b32.oOp, b32.oS1, b32.oS2, b32.oUnsignedFlg, b32.oTag} !== {e.op[1:0], e.s1[31:0], e.s2[31:0], e.uns, e.tag}) begin
               errors++;
               $display("FAIL mon32: got op=%b s1=%h s2=%h u=%b tag=%0d expected op=%b s1=%h s2=%h u=%b tag=%0d",
                        b32.oOp, b32.oS1, b32.oS2, b32.oUnsignedFlg, b32.oTag, e.op[1:0], e.s1[31:0], e.s2[31:0], e.uns, e.tag);
            end
         end
      end
   end
   // holds iVld until the stage is ready, recording the expectation when the accept is certain
   task automatic send(input bit w, input add_sub_kind_e k, input logic [63:0] rs1, rs2, imm, pc,
                       input logic [3:0] tag, input exp_t e);
      bit done = 0;
      if (w) begin
         b64.iVld = 1; b64.iKind = k; b64.iRs1 = rs1; b64.iRs2 = rs2; b64.iImm = imm; b64.iPc = pc; b64.iTag = tag;
      end else begin
         b32.iVld = 1; b32.iKind = k; b32.iRs1 = rs1[31:0]; b32.iRs2 = rs2[31:0]; b32.iImm = imm[31:0]; b32.iPc = pc[31:0]; b32.iTag = tag;
      end
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (w ? b64.oRdy : b32.oRdy) begin
            if (w) q64.push_back(e); else q32.push_back(e);
            done = 1;
         end
         @(posedge clk);
      end
      #1;
      b64.iVld = 0;
      b32.iVld = 0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send: tag %0d never accepted", tag);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      {b64.iFlush, b64.iVld, b64.iRs1, b64.iRs2, b64.iImm, b64.iPc, b64.iTag} = '0;
      {b32.iFlush, b32.iVld, b32.iRs1, b32.iRs2, b32.iImm, b32.iPc, b32.iTag} = '0;
      b64.iKind = ADD; b32.iKind = ADD;
      b64.iRdy = 1; b32.iRdy = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst oVld", 64'(b64.oVld), 0);
      chk("rst oRdy", 64'(b64.oRdy), 1);
      chk("rst oOp", 64'(b64.oOp), 0);
      chk("rst oS1", b64.oS1, 0);
      chk("rst oS2", b64.oS2, 0);
      chk("rst oUnsignedFlg", 64'(b64.oUnsignedFlg), 0);
      chk("rst oTag", 64'(b64.oTag), 0);
      chk("rst oIllegal64", 64'(b64.oIllegal), 0);
      chk("rst oIllegal32", 64'(b32.oIllegal), 0);
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
      chk("rst oIssueCnt", 64'(b64.oIssueCnt), 0);
      chk("rst oStallCnt", 64'(b64.oStallCnt), 0);
`endif
      @(posedge clk); #1;
      send(0, ADDI, 64'h10, 0, 64'hFFFF_FFFC, 0, 4'd1, mk(3'b001, 64'h10, 64'hFFFF_FFFC, 0, 4'd1));
      @(negedge clk);
      chk("addi32 latency oVld", 64'(b32.oVld), 1);
      @(posedge clk); #1;
      send(1, SUBW,  64'd5, 64'd7, 0, 0, 4'd2, mk(3'b110, 64'd5, 64'd7, 0, 4'd2));
      send(1, SLTIU, 64'd9, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd3, mk(3'b010, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'd3));
      send(1, AUIPC, 64'd1, 64'd2, 64'h1000, 64'h8000_0000, 4'd4, mk(3'b001, 64'h8000_0000, 64'h1000, 0, 4'd4));
      send(1, BGEU,  64'd1, 64'd2, 64'd3, 0, 4'd5, mk(3'b010, 64'd1, 64'd2, 1, 4'd5));
      send(1, ADDIW, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'd6, mk(3'b101, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'd6));
      send(1, LDST,  64'h100, 64'd4, 64'd8, 0, 4'd7, mk(3'b001, 64'h100, 64'd8, 0, 4'd7));
      send(1, SLT,   64'hA, 64'hB, 64'd8, 0, 4'd8, mk(3'b010, 64'hA, 64'hB, 0, 4'd8));
      repeat (3) @(posedge clk);
      chk("drain64 directed", 64'(q64.size()), 0);
      #1 b64.iRdy = 0;
      send(1, ADD, 64'd1, 64'd1, 0, 0, 4'd1, mk(3'b001, 64'd1, 64'd1, 0, 4'd1));
      send(1, SUB, 64'd10, 64'd3, 0, 0, 4'd2, mk(3'b010, 64'd10, 64'd3, 0, 4'd2));
      @(negedge clk);
      chk("full oRdy", 64'(b64.oRdy), 0);
      chk("full oVld", 64'(b64.oVld), 1);
      fork
         send(1, ADDI, 64'd20, 0, 64'd5, 0, 4'd3, mk(3'b001, 64'd20, 64'd5, 0, 4'd3));
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall held tag", 64'(b64.oTag), 1);
               chk("stall held oRdy", 64'(b64.oRdy), 0);
            end
            @(posedge clk);
            #1 b64.iRdy = 1;
         end
      join
      repeat (4) @(posedge clk);
      chk("drain64 backpressure", 64'(q64.size()), 0);
      #1 b64.iRdy = 0;
      send(1, ADD, 64'd1, 64'd2, 0, 0, 4'd8, mk(3'b001, 64'd1, 64'd2, 0, 4'd8));
      send(1, ADD, 64'd3, 64'd4, 0, 0, 4'd9, mk(3'b001, 64'd3, 64'd4, 0, 4'd9));
      b64.iFlush = 1; b64.iVld = 1; b64.iKind = ADD; b64.iTag = 4'd10;
      @(posedge clk);
      #1 b64.iFlush = 0; b64.iVld = 0;
      q64.delete();
      @(negedge clk);
      chk("flush oVld", 64'(b64.oVld), 0);
      chk("flush oRdy", 64'(b64.oRdy), 1);
      b64.iRdy = 1;
      repeat (5) @(posedge clk);
      chk("flush oIllegal64", 64'(b64.oIllegal), 0);
      #1;
      send(0, ADDW, 64'd1, 64'd2, 0, 0, 4'd5, mk(3'b000, 0, 0, 0, 4'd5));
      @(negedge clk);
      chk("rv32 addw oIllegal", 64'(b32.oIllegal), 1);
      @(posedge clk);
      #1 b32.iFlush = 1;
      @(posedge clk);
      #1 b32.iFlush = 0;
      @(negedge clk);
      chk("oIllegal sticky over flush", 64'(b32.oIllegal), 1);
      @(posedge clk);
      #1 b64.iRdy = 0;
      send(1, SUB, 64'd7, 64'd1, 0, 0, 4'd11, mk(3'b010, 64'd7, 64'd1, 0, 4'd11));
      send(1, ADD, 64'd7, 64'd1, 0, 0, 4'd12, mk(3'b001, 64'd7, 64'd1, 0, 4'd12));
      @(negedge clk);
      chk("pre-reset oVld", 64'(b64.oVld), 1);
      #2 rst_n = 0;
      #1;
      q64.delete();
      chk("async rst oVld", 64'(b64.oVld), 0);
      chk("async rst oRdy", 64'(b64.oRdy), 1);
      chk("async rst oOp", 64'(b64.oOp), 0);
      chk("async rst oS1", b64.oS1, 0);
      chk("async rst oTag", 64'(b64.oTag), 0);
      chk("async rst oIllegal32", 64'(b32.oIllegal), 0);
`ifdef ZION_ADD_SUB_ISSUE_PERF_EN
      chk("async rst oIssueCnt", 64'(b64.oIssueCnt), 0);
      chk("async rst oStallCnt", 64'(b64.oStallCnt), 0);
`endif
      @(posedge clk);
      #1 rst_n = 1; b64.iRdy = 1;
      send(1, SLTU, 64'd3, 64'd4, 0, 0, 4'd13, mk(3'b010, 64'd3, 64'd4, 1, 4'd13));
      repeat (3) @(posedge clk);
      chk("final drain64", 64'(q64.size()), 0);
      chk("final drain32", 64'(q32.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
